// File: rtl/uart_prog_loader.sv
// UART programmer byte-stream loader: parses SYNC/target/count framing and emits
// little-endian 32-bit word writes on the upg_* port, flagging completion or abort.
module uart_prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              upg_wen,
    output logic [ADDR_W:0]   upg_adr,
    output logic [31:0]       upg_dat,
    output logic              upg_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_TGT, S_CNT_LO, S_CNT_HI, S_DATA, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t            state_q;
    logic              target_q;
    logic [15:0]       cnt_q;
    logic [15:0]       word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       buf_q;
    logic [31:0]       idle_q;
    logic              wen_q;
    logic [ADDR_W:0]   adr_q;
    logic [31:0]       dat_q;
    logic              done_q;
    logic              busy_q;
    logic              err_q;

    logic [15:0]       cnt_d;
    logic [31:0]       idle_d;
    logic              timeout_d;
    logic              last_write_d;

    always_comb begin
        cnt_d        = {rx_data, cnt_q[7:0]};
        idle_d       = idle_q + 32'd1;
        timeout_d    = (idle_d >= 32'(TIMEOUT_CYCLES));
        // word_idx has already advanced past the final word during its write cycle
        last_write_d = (state_q == S_DATA) && wen_q && (word_idx_q == cnt_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            idle_q     <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_q <= S_TGT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        idle_q  <= '0;
                    end
                end
                default: begin
                    if (last_write_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!rx_valid) begin
                        idle_q <= idle_d;
                        if (timeout_d) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end else begin
                        idle_q <= '0;
                        case (state_q)
                            S_TGT: begin
                                if (rx_data[7:1] == 7'd0) begin
                                    target_q <= rx_data[0];
                                    state_q  <= S_CNT_LO;
                                end else begin
                                    state_q <= S_ERR;
                                    busy_q  <= 1'b0;
                                    err_q   <= 1'b1;
                                end
                            end
                            S_CNT_LO: begin
                                cnt_q[7:0] <= rx_data;
                                state_q    <= S_CNT_HI;
                            end
                            S_CNT_HI: begin
                                cnt_q[15:8] <= rx_data;
                                if (cnt_d == 16'd0) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else if ({16'd0, cnt_d} > MAX_WORDS) begin
                                    state_q <= S_ERR;
                                    busy_q  <= 1'b0;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q    <= S_DATA;
                                    word_idx_q <= '0;
                                    byte_idx_q <= '0;
                                end
                            end
                            S_DATA: begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                                case (byte_idx_q)
                                    2'd0: buf_q[7:0]   <= rx_data;
                                    2'd1: buf_q[15:8]  <= rx_data;
                                    2'd2: buf_q[23:16] <= rx_data;
                                    default: begin
                                        wen_q      <= 1'b1;
                                        adr_q      <= {target_q, word_idx_q[ADDR_W-1:0]};
                                        dat_q      <= {rx_data, buf_q};
                                        word_idx_q <= word_idx_q + 16'd1;
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign upg_wen  = wen_q;
    assign upg_adr  = adr_q;
    assign upg_dat  = dat_q;
    assign upg_done = done_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
